// File: rtl/ppu_pkg.sv
// Shared PPU types: mode encoding, framebuffer writer states and geometry defaults.
package ppu_pkg;

  typedef enum logic [1:0] {
    H_BLANK = 2'd0,
    V_BLANK = 2'd1,
    SCAN    = 2'd2,
    DRAW    = 2'd3
  } ppu_mode_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    LINE_END = 2'd2,
    WAIT     = 2'd3
  } wr_state_e;

  localparam int H_PIXELS_DEF       = 160;
  localparam int V_LINES_DEF        = 144;
  localparam int BYTES_PER_LINE_DEF = H_PIXELS_DEF / 4;

  // Left-justify a partially filled pack register; unused low pixels read as 2'b00.
  function automatic logic [7:0] pad_byte(input logic [7:0] r, input logic [1:0] cnt);
    case (cnt)
      2'd1:    pad_byte = {r[1:0], 6'b0};
      2'd2:    pad_byte = {r[3:0], 4'b0};
      2'd3:    pad_byte = {r[5:0], 2'b0};
      default: pad_byte = r;
    endcase
  endfunction

endpackage

// File: rtl/ppu_fb_fifo.sv
// Synchronous FIFO of {addr, data} words; push and pop together are accepted even when full.
module ppu_fb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/ppu_fb_writer.sv
// Packs the PPU 2-bit pixel stream four-per-byte into framebuffer writes.
// Build option PPU_FB_PALETTE_EN maps each pixel through bgp before packing.
module ppu_fb_writer
  import ppu_pkg::*;
#(
  parameter logic [15:0] FB_BASE    = 16'h0000,
  parameter int          H_PIXELS   = H_PIXELS_DEF,
  parameter int          V_LINES    = V_LINES_DEF,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  px_in,
  input  logic        px_valid,
  input  logic [1:0]  ppu_mode,
  input  logic [7:0]  bgp,
  output logic [15:0] fb_addr,
  output logic [7:0]  fb_data,
  output logic        fb_valid,
  input  logic        fb_ready,
  output logic        line_done,
  output logic        frame_done,
  output logic        overflow,
  output logic [7:0]  x_cnt,
  output logic [7:0]  y_cnt
);

  localparam logic [7:0]  H_MAX  = 8'(H_PIXELS);
  localparam logic [7:0]  Y_LAST = 8'(V_LINES - 1);
  localparam logic [15:0] BPL    = 16'(H_PIXELS / 4);

  wr_state_e   state, state_nxt;
  ppu_mode_e   mode;
  logic [7:0]  pack_reg;
  logic [1:0]  pack_cnt;
  logic [1:0]  shade;
  logic        accept;
  logic        push;
  logic [7:0]  push_data;
  logic [15:0] line_addr;
  logic [23:0] head;
  logic        fifo_full;
  logic        fifo_empty;

  assign mode = ppu_mode_e'(ppu_mode);

`ifdef PPU_FB_PALETTE_EN
  assign shade = bgp[{px_in, 1'b0} +: 2];
`else
  logic unused_bgp;
  assign unused_bgp = ^bgp;
  assign shade      = px_in;
`endif

  assign accept    = (state == ACTIVE) && px_valid && (x_cnt < H_MAX);
  assign line_addr = FB_BASE + ({8'b0, y_cnt} * BPL) + {10'b0, x_cnt[7:2]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    push_data = 8'h00;
    case (state)
      IDLE: if (mode == DRAW) state_nxt = ACTIVE;
      ACTIVE: begin
        if (mode != DRAW) state_nxt = LINE_END;
        if (accept && (pack_cnt == 2'd3)) begin
          push      = 1'b1;
          push_data = {pack_reg[5:0], shade};
        end
      end
      LINE_END: begin
        state_nxt = WAIT;
        if (pack_cnt != 2'd0) begin
          push      = 1'b1;
          push_data = pad_byte(pack_reg, pack_cnt);
        end
      end
      WAIT: begin
        if (mode == DRAW)         state_nxt = ACTIVE;
        else if (mode == V_BLANK) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_cnt      <= 8'd0;
      y_cnt      <= 8'd0;
      pack_reg   <= 8'd0;
      pack_cnt   <= 2'd0;
      line_done  <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      line_done  <= 1'b0;
      frame_done <= 1'b0;
      if (accept) begin
        x_cnt <= x_cnt + 8'd1;
        if (pack_cnt == 2'd3) begin
          pack_reg <= 8'd0;
          pack_cnt <= 2'd0;
        end else begin
          pack_reg <= {pack_reg[5:0], shade};
          pack_cnt <= pack_cnt + 2'd1;
        end
      end
      if (state == LINE_END) begin
        pack_reg <= 8'd0;
        pack_cnt <= 2'd0;
        if (x_cnt != 8'd0) begin
          line_done <= 1'b1;
          x_cnt     <= 8'd0;
          if (y_cnt == Y_LAST) begin
            y_cnt      <= 8'd0;
            frame_done <= 1'b1;
          end else begin
            y_cnt <= y_cnt + 8'd1;
          end
        end
      end
      // Vertical blank resynchronises the raster without claiming a frame.
      if (((state == IDLE) || (state == WAIT)) && (mode == V_BLANK)) begin
        x_cnt <= 8'd0;
        y_cnt <= 8'd0;
      end
      if (push && fifo_full && !fb_ready) overflow <= 1'b1;
    end
  end

  ppu_fb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (24)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({line_addr, push_data}),
    .pop   (fb_ready),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Valid/ready: a write transfers on a cycle with fb_valid && fb_ready; head holds while stalled.
  assign fb_valid = !fifo_empty;
  assign fb_addr  = fifo_empty ? FB_BASE : head[23:8];
  assign fb_data  = fifo_empty ? 8'h00   : head[7:0];

endmodule

// File: tb/tb_ppu_fb_writer.sv
// Scoreboard bench for ppu_fb_writer: driver tasks push expected writes, a monitor pops and compares.
module tb_ppu_fb_writer;
  import ppu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  px_in;
  logic        px_valid;
  logic [1:0]  ppu_mode;
  logic [7:0]  bgp_v;
  logic [15:0] fb_addr;
  logic [7:0]  fb_data;
  logic        fb_valid;
  logic        fb_ready;
  logic        line_done;
  logic        frame_done;
  logic        overflow;
  logic [7:0]  x_cnt;
  logic [7:0]  y_cnt;

  logic [23:0] exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          line_pulses = 0;
  int          frame_pulses = 0;
  logic [15:0] last_addr = 16'hFFFF;
  bit          hold_prev = 1'b0;
  logic [23:0] prev_head = '0;

  always #5 clk = ~clk;

  ppu_fb_writer dut (
    .clk        (clk),
    .rst        (rst),
    .px_in      (px_in),
    .px_valid   (px_valid),
    .ppu_mode   (ppu_mode),
    .bgp        (bgp_v),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .fb_valid   (fb_valid),
    .fb_ready   (fb_ready),
    .line_done  (line_done),
    .frame_done (frame_done),
    .overflow   (overflow),
    .x_cnt      (x_cnt),
    .y_cnt      (y_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (line_done) line_pulses++;
      if (frame_done) begin
        frame_pulses++;
        check("frame_with_line", {31'b0, line_done}, 32'd1);
      end
      if (fb_valid && hold_prev) check("hold_stable", {8'b0, fb_addr, fb_data}, {8'b0, prev_head});
      if (fb_valid && fb_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got %h with no write expected", {fb_addr, fb_data});
        end else begin
          logic [23:0] e;
          e = exp_q.pop_front();
          check("write", {8'b0, fb_addr, fb_data}, {8'b0, e});
          last_addr = fb_addr;
        end
      end
      hold_prev = fb_valid && !fb_ready;
      prev_head = {fb_addr, fb_data};
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [1:0] pix(input int kind, input int i);
    case (kind)
      0:       pix = 2'(i % 4);
      1:       pix = 2'b11;
      default: pix = 2'b00;
    endcase
  endfunction

  // Model of one line's packed writes at row y, truncated to max_bytes.
  task automatic expect_line(input int y, input int n, input int kind, input int max_bytes);
    int nv, nb;
    logic [7:0] d, s;
    nv = (n > 160) ? 160 : n;
    nb = (nv + 3) / 4;
    if (nb > max_bytes) nb = max_bytes;
    for (int b = 0; b < nb; b++) begin
      d = 8'h00;
      for (int k = 0; k < 4; k++) begin
        if (4 * b + k < nv) begin
          s = {6'b0, pix(kind, 4 * b + k)};
          d = d | (s << (6 - 2 * k));
        end
      end
      exp_q.push_back({16'(y * 40 + b), d});
    end
  endtask

  task automatic start_draw();
    ppu_mode = 2'd3;
    px_valid = 1'b0;
    tick(1);
  endtask

  task automatic feed(input int n, input int kind);
    for (int i = 0; i < n; i++) begin
      px_in    = pix(kind, i);
      px_valid = 1'b1;
      tick(1);
    end
    px_valid = 1'b0;
  endtask

  task automatic end_line();
    ppu_mode = 2'd0;
    tick(4);
  endtask

  task automatic vblank();
    ppu_mode = 2'd1;
    tick(3);
    ppu_mode = 2'd0;
    tick(1);
  endtask

  task automatic wait_drain(input string name);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < 2000) begin
      tick(1);
      c++;
    end
    tick(1);
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    int lp, fp;
    rst      = 1'b1;
    ppu_mode = 2'd0;
    px_valid = 1'b0;
    px_in    = 2'd0;
    fb_ready = 1'b1;
    bgp_v    = 8'hE4;
    #1;
    check("rst_fb_valid", {31'b0, fb_valid}, 0);
    check("rst_fb_addr", {16'b0, fb_addr}, 32'h0000);
    check("rst_fb_data", {24'b0, fb_data}, 0);
    check("rst_x", {24'b0, x_cnt}, 0);
    check("rst_y", {24'b0, y_cnt}, 0);
    check("rst_flags", {29'b0, line_done, frame_done, overflow}, 0);
    tick(2);
    rst = 1'b0;
    tick(1);

    // 1: full line of 0,1,2,3 -> 40 x 8'h1B, extra pixels past the edge dropped
    lp = line_pulses;
    expect_line(0, 160, 0, 40);
    start_draw();
    feed(164, 0);
    check("t1_x_saturate", {24'b0, x_cnt}, 160);
    end_line();
    wait_drain("t1_drain");
    check("t1_last_addr", {16'b0, last_addr}, 32'h0027);
    check("t1_line_done", line_pulses - lp, 1);
    check("t1_y", {24'b0, y_cnt}, 1);
    check("t1_x", {24'b0, x_cnt}, 0);

    // DRAW with no accepted pixels leaves the line counter alone
    lp = line_pulses;
    start_draw();
    end_line();
    check("empty_line_y", {24'b0, y_cnt}, 1);
    check("empty_line_pulse", line_pulses - lp, 0);
    check("empty_line_q", exp_q.size(), 0);

    // V_BLANK resync without frame_done
    fp = frame_pulses;
    vblank();
    check("vblank_y", {24'b0, y_cnt}, 0);
    check("vblank_no_frame", frame_pulses - fp, 0);

    // 2: partial line of six 2'b11 pixels
    lp = line_pulses;
    exp_q.push_back({16'h0000, 8'hFF});
    exp_q.push_back({16'h0001, 8'hF0});
    start_draw();
    feed(6, 1);
    end_line();
    wait_drain("t2_drain");
    check("t2_line_done", line_pulses - lp, 1);
    check("t2_y", {24'b0, y_cnt}, 1);

    // 3: full frame of 144 lines
    vblank();
    lp = line_pulses;
    fp = frame_pulses;
    for (int y = 0; y < 144; y++) begin
      expect_line(y, 160, 0, 40);
      start_draw();
      feed(160, 0);
      end_line();
    end
    wait_drain("t3_drain");
    check("t3_last_addr", {16'b0, last_addr}, 32'h167F);
    check("t3_lines", line_pulses - lp, 144);
    check("t3_frames", frame_pulses - fp, 1);
    check("t3_y", {24'b0, y_cnt}, 0);
    check("t3_no_overflow", {31'b0, overflow}, 0);

    // 4: stalled memory, 5 bytes into a 4-deep FIFO
    fb_ready = 1'b0;
    expect_line(0, 20, 0, 4);
    start_draw();
    feed(20, 0);
    end_line();
    check("t4_overflow", {31'b0, overflow}, 1);
    check("t4_valid_held", {31'b0, fb_valid}, 1);
    tick(3);
    fb_ready = 1'b1;
    wait_drain("t4_drain");
    tick(2);
    check("t4_empty_after", {31'b0, fb_valid}, 0);
    check("t4_overflow_sticky", {31'b0, overflow}, 1);

    // 5: reset mid-line with writes pending
    vblank();
    fb_ready = 1'b0;
    start_draw();
    feed(50, 0);
    check("t5_pending", {31'b0, fb_valid}, 1);
    check("t5_x_before", {24'b0, x_cnt}, 50);
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("t5_fb_valid", {31'b0, fb_valid}, 0);
    check("t5_fb_addr", {16'b0, fb_addr}, 32'h0000);
    check("t5_fb_data", {24'b0, fb_data}, 0);
    check("t5_x", {24'b0, x_cnt}, 0);
    check("t5_y", {24'b0, y_cnt}, 0);
    check("t5_flags", {29'b0, line_done, frame_done, overflow}, 0);
    ppu_mode = 2'd0;
    fb_ready = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    expect_line(0, 8, 0, 40);
    start_draw();
    feed(8, 0);
    end_line();
    wait_drain("t5_drain");
    check("t5_last_addr", {16'b0, last_addr}, 32'h0001);

`ifdef PPU_FB_PALETTE_EN
    // 6: palette mapping of pixel 0
    vblank();
    bgp_v = 8'hE4;
    exp_q.push_back({16'h0000, 8'h00});
    start_draw();
    feed(4, 2);
    end_line();
    wait_drain("t6_e4");
    vblank();
    bgp_v = 8'h1B;
    exp_q.push_back({16'h0000, 8'hFF});
    start_draw();
    feed(4, 2);
    end_line();
    wait_drain("t6_1b");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
